// File: rtl/multi_line_buffer.sv
// multi_line_buffer: vertical pixel window generator for raster video.
// Keeps NUM_LINES-1 line stores. Each accepted pixel shifts one column of the
// window down by one row. The result is registered as a column of NUM_LINES taps:
// slice 0 holds the current row and the highest slice holds the oldest row.
// Optional build macro MULTI_LINE_BUFFER_ZERO_PAD_EN: when it is defined, taps
// are emitted from row 0 onward, and rows not yet filled are forced to zero.

// One line of pixel history. The write is synchronous and the read is
// asynchronous at the same address. This lets a column be read and shifted
// in a single cycle. The contents are never reset.
module mlb_line_store #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 480
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  // On each accepted pixel, write the column value pushed down from the row above.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];
endmodule

module multi_line_buffer #(
  parameter int WIDTH     = 16,
  parameter int IMG_WIDTH = 480,
  parameter int NUM_LINES = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sof,
  input  logic [WIDTH-1:0]             din,
  input  logic                         valid_in,
  output logic [NUM_LINES*WIDTH-1:0]   taps,
  output logic                         valid_out,
  output logic                         eol_out,
  output logic [$clog2(IMG_WIDTH)-1:0] col_out
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(NUM_LINES);
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] FULL     = RW'(NUM_LINES - 1);

  logic [CW-1:0] col, cur_col, col_nxt;
  logic [RW-1:0] rows_filled, cur_rows, rows_nxt;
  logic          wrap, valid_nxt;

  logic [NUM_LINES-2:0][WIDTH-1:0] rd;
  logic [NUM_LINES-1:0][WIDTH-1:0] col_vec, tap_nxt;

  // A pixel that carries sof always opens a new frame at column 0, row 0.
  // This holds wherever the counters currently stand.
  always_comb begin
    cur_col  = sof ? '0 : col;
    cur_rows = sof ? '0 : rows_filled;
    wrap     = (cur_col == LAST_COL);
    col_nxt  = wrap ? '0 : cur_col + 1'b1;
    rows_nxt = (wrap && cur_rows != FULL) ? cur_rows + 1'b1 : cur_rows;
  end

  // Store k receives what store k-1 (or din, for k=0) holds at this column.
  // The result is a vertical shift of the column.
  for (genvar k = 0; k < NUM_LINES - 1; k++) begin : g_line
    logic [WIDTH-1:0] wdata;
    if (k == 0) begin : g_head
      assign wdata = din;
    end else begin : g_body
      assign wdata = rd[k-1];
    end
    mlb_line_store #(.WIDTH(WIDTH), .DEPTH(IMG_WIDTH)) u_store (
      .clk   (clk),
      .we    (valid_in),
      .addr  (cur_col),
      .wdata (wdata),
      .rdata (rd[k])
    );
  end

  assign col_vec = {rd, din};

`ifdef MULTI_LINE_BUFFER_ZERO_PAD_EN
  // Emit every pixel. Blank the slices whose rows have not been written in this frame.
  always_comb begin
    tap_nxt   = col_vec;
    valid_nxt = 1'b1;
    for (int k = 1; k < NUM_LINES; k++)
      if (k > int'(cur_rows)) tap_nxt[k] = '0;
  end
`else
  // Emit only once every slice holds a row of the current frame.
  always_comb begin
    tap_nxt   = col_vec;
    valid_nxt = (cur_rows == FULL);
  end
`endif

  // Position counters advance only on accepted pixels, so gaps in valid_in are harmless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col         <= '0;
      rows_filled <= '0;
    end else if (valid_in) begin
      col         <= col_nxt;
      rows_filled <= rows_nxt;
    end
  end

  // Output register. taps and col_out hold through idle cycles.
  // The strobes are high only for the cycle after an accepted pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taps      <= '0;
      col_out   <= '0;
      valid_out <= 1'b0;
      eol_out   <= 1'b0;
    end else if (valid_in) begin
      taps      <= tap_nxt;
      col_out   <= cur_col;
      valid_out <= valid_nxt;
      eol_out   <= valid_nxt && wrap;
    end else begin
      valid_out <= 1'b0;
      eol_out   <= 1'b0;
    end
  end
endmodule

// File: tb/tb_multi_line_buffer.sv
// Directed bench for multi_line_buffer (WIDTH=8, IMG_WIDTH=4, NUM_LINES=3).
// When MULTI_LINE_BUFFER_ZERO_PAD_EN is defined, the expected values follow the zero-pad build.
module tb_multi_line_buffer;
  localparam int W = 8, IW = 4, NL = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            sof = 1'b0;
  logic [W-1:0]    din = '0;
  logic            valid_in = 1'b0;
  logic [NL*W-1:0] taps;
  logic            valid_out, eol_out;
  logic [1:0]      col_out;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

`ifdef MULTI_LINE_BUFFER_ZERO_PAD_EN
  localparam bit ZP = 1'b1;
`else
  localparam bit ZP = 1'b0;
`endif

  multi_line_buffer #(.WIDTH(W), .IMG_WIDTH(IW), .NUM_LINES(NL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sof       (sof),
    .din       (din),
    .valid_in  (valid_in),
    .taps      (taps),
    .valid_out (valid_out),
    .eol_out   (eol_out),
    .col_out   (col_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one input cycle, then return 1 time unit after the capturing edge.
  task automatic drive(input logic s, input logic [W-1:0] d, input logic v);
    @(negedge clk);
    sof = s; din = d; valid_in = v;
    @(posedge clk);
    #1;
  endtask

  // Pixel q (1-based) of a frame carries the value base+q.
  // The rows above it carry the values from 4 and 8 pixels earlier.
  function automatic logic [23:0] exp_taps(input int base, input int q);
    logic [7:0] s0, s1, s2;
    s0 = 8'(base + q);
    s1 = (q > 4) ? 8'(base + q - 4) : 8'h00;
    s2 = (q > 8) ? 8'(base + q - 8) : 8'h00;
    return {s2, s1, s0};
  endfunction

  // Stream n pixels of one frame.
  // first_sof sets sof on the first pixel. gap inserts that many idle cycles after each pixel.
  task automatic run_frame(input string tag, input int base, input int n,
                           input bit first_sof, input int gap);
    for (int q = 1; q <= n; q++) begin
      int c;
      bit vexp;
      logic [23:0] texp;
      c    = (q - 1) % 4;
      vexp = ZP || (q > 8);
      texp = exp_taps(base, q);
      drive(first_sof && q == 1, 8'(base + q), 1'b1);
      chk($sformatf("%s p%0d valid", tag, q), valid_out, vexp);
      chk($sformatf("%s p%0d col", tag, q), col_out, c);
      chk($sformatf("%s p%0d eol", tag, q), eol_out, vexp && c == 3);
      if (vexp) chk($sformatf("%s p%0d taps", tag, q), taps, texp);
      for (int g = 0; g < gap; g++) begin
        drive(1'b0, 8'hEE, 1'b0);
        chk($sformatf("%s p%0d idle valid", tag, q), valid_out, 0);
        chk($sformatf("%s p%0d idle eol", tag, q), eol_out, 0);
        chk($sformatf("%s p%0d idle col", tag, q), col_out, c);
        if (vexp) chk($sformatf("%s p%0d idle taps", tag, q), taps, texp);
      end
    end
  endtask

  // Continue with a pixel that is not the start of a frame, against hand-computed values.
  task automatic pix(input string tag, input logic [7:0] d, input int c,
                     input bit e, input logic [23:0] t);
    drive(1'b0, d, 1'b1);
    chk({tag, " valid"}, valid_out, 1);
    chk({tag, " col"}, col_out, c);
    chk({tag, " eol"}, eol_out, e);
    chk({tag, " taps"}, taps, t);
  endtask

  initial begin
    // Reset state.
    #1 rst_n = 1'b0;
    #3;
    chk("reset taps", taps, 0);
    chk("reset valid", valid_out, 0);
    chk("reset eol", eol_out, 0);
    chk("reset col", col_out, 0);
    @(negedge clk) rst_n = 1'b1;

    // Contiguous fill. Pixel 9 gives {1,5,9}; pixel 12 gives {4,8,12} with eol set.
    run_frame("fill", 0, 12, 1'b1, 0);

    // Same stream with two idle cycles after each pixel.
    run_frame("gap", 0, 12, 1'b1, 2);

    // Once saturated, the rows keep rolling across a line wrap without sof.
    pix("roll101", 8'd101, 0, 1'b0, 24'h050965);
    pix("roll102", 8'd102, 1, 1'b0, 24'h060A66);
    pix("roll103", 8'd103, 2, 1'b0, 24'h070B67);
    pix("roll104", 8'd104, 3, 1'b1, 24'h080C68);
    pix("roll105", 8'd105, 0, 1'b0, 24'h096569);

    // The sof on pixel 6 (column 1) restarts at column 0, and the refill is masked again.
    run_frame("midsof", 20, 12, 1'b1, 0);

    // Three frames back to back.
    run_frame("cont0", 40, 12, 1'b1, 0);
    run_frame("cont1", 60, 12, 1'b1, 0);
    run_frame("cont2", 80, 12, 1'b1, 0);

    // Assert reset mid-stream, away from any clock edge.
    run_frame("prerst", 100, 10, 1'b1, 0);
    @(negedge clk);
    valid_in = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst taps", taps, 0);
    chk("midrst valid", valid_out, 0);
    chk("midrst eol", eol_out, 0);
    chk("midrst col", col_out, 0);
    @(negedge clk) rst_n = 1'b1;

    // The first pixel after release is column 0, row 0, even without sof.
    run_frame("postrst", 120, 12, 1'b0, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
